fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Downstream consumer of the Fifo block. Drains bytes from the Fifo read port and serialises each one as a UART frame: 1 start bit, WIDTH data bits LSB-first, then 1 stop bit. It drives the Fifo read strobe iRDCLKN, where the falling edge pops a word. It sits between the Fifo and the board TX pin.

Parameters:
CLKS_PER_BIT, 434, iCLK cycles per UART bit (434 gives 115200 baud at 50 MHz); legal minimum 4.
WIDTH, 8, data bits per frame; must equal the Fifo WIDTH.
RD_LOW_CYCLES, 2, cycles oRdClkN is held low per pop; iData is sampled on the last low cycle; legal minimum 1.

Ports:
iCLK  in  1  system clock; all logic is rising-edge.
iRSTN  in  1  asynchronous active-low reset.
iData  in  WIDTH  Fifo oData.
iEmpty  in  1  Fifo oEmpty; asynchronous to iCLK.
iEnable  in  1  1 = permitted to start new frames.
oRdClkN  out  1  connects to Fifo iRDCLKN; idles high; low pulse = pop.
oTx  out  1  serial line; idles high.
oBusy  out  1  high from POP entry until the stop bit completes.
oFrameDone  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async, while iRSTN=0): oTx=1, oRdClkN=1, oBusy=0, oFrameDone=0, FSM=IDLE, all counters=0. No frame is in progress after reset. Asserting reset mid-frame aborts the frame immediately and forces oTx high; the partial byte is lost.
- iEmpty passes through a 2-flop synchroniser to give empty_s. The raw iEmpty is never used directly.
- FSM states: IDLE, POP, START, DATA, STOP.
- IDLE: if iEnable=1 and empty_s=0, go to POP next cycle. Otherwise stay in IDLE.
- POP: oRdClkN=0 for exactly RD_LOW_CYCLES cycles. On the last low cycle, iData is latched into the shift register. The next state is START; oRdClkN returns to 1 on the same edge.
- START: oTx=0 for CLKS_PER_BIT cycles.
- DATA: oTx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. Exactly WIDTH bits are sent; the bit index runs 0..WIDTH-1 and does not wrap.
- STOP: oTx=1 for CLKS_PER_BIT cycles. oFrameDone=1 on the final cycle. Next state is IDLE.
- Latency: from empty_s falling to the first oRdClkN low is 1 cycle. From the oRdClkN rising edge to the oTx start edge is 0 cycles (same edge).
- Back-to-back frames: IDLE lasts exactly 1 cycle between frames when data is pending. Synchroniser staleness is harmless because a frame is always ≥ 10×CLKS_PER_BIT cycles.
- iEnable is checked only in IDLE. Deasserting it mid-frame has no effect until the frame completes.
- Fifo pop count equals frame count exactly. The block never strobes while empty_s=1.
- Baud counter: width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.

Optional Feature:
UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the WIDTH data bits) for CLKS_PER_BIT cycles. Frame length becomes WIDTH+3 bits.
- Undefined: no PARITY state, no parity logic. Frame length is WIDTH+2 bits.

Test Plan:
1. Reset with CLKS_PER_BIT=8 → oTx=1, oRdClkN=1, oBusy=0. Hold iEmpty=1 for 200 cycles → oRdClkN never goes low.
2. Fifo preloaded with 0x5A, iEnable=1 → exactly one oRdClkN low pulse of 2 cycles. oTx shows 0, then 0,1,0,1,1,0,1,0 (LSB-first), then 1, each held 8 cycles. oFrameDone pulses once, 80 cycles after the start edge.
3. Fifo preloaded with 0x00..0x0E (15 words) → 15 frames are decoded in order 0x00..0x0E with 1 idle cycle between them. The pop count is 15, and Fifo oEmpty is 1 afterwards.
4. Assert iRSTN=0 during data bit 3 of byte 0xFF → oTx goes 1 asynchronously and oBusy goes 0. After release, the next Fifo byte is sent complete and the aborted byte is not re-sent.
5. iEnable=0 with 4 bytes queued → no pop for 500 cycles. Drop iEnable during frame 2 → frame 2 completes and frame 3 does not start.
6. With UART_TX_PARITY_EN defined, send 0x07 → parity bit=1 and frame is 11 bits. Send 0x03 → parity bit=0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a Fifo through its active-low read strobe and sends
// each word as a UART frame: start bit, WIDTH data bits LSB-first, stop bit.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit (frame becomes WIDTH+3 bits).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned RD_LOW_CYCLES = 2
) (
  input  logic             iCLK,
  input  logic             iRSTN,
  input  logic [WIDTH-1:0] iData,
  input  logic             iEmpty,
  input  logic             iEnable,
  output logic             oRdClkN,
  output logic             oTx,
  output logic             oBusy,
  output logic             oFrameDone
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1)  ? $clog2(CLKS_PER_BIT)  : 1;
  localparam int unsigned RD_W   = (RD_LOW_CYCLES > 1) ? $clog2(RD_LOW_CYCLES) : 1;
  localparam int unsigned BIT_W  = (WIDTH > 1)         ? $clog2(WIDTH)         : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PEN  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(RD_LOW_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  state_e            state_q;
  logic              empty_meta_q;
  logic              empty_s_q;
  logic [BAUD_W-1:0] baud_q;
  logic [RD_W-1:0]   rd_q;
  logic [BIT_W-1:0]  bit_q;
  logic [WIDTH-1:0]  shift_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic baud_last_c;
  logic baud_pen_c;
  logic rd_last_c;
  logic bit_last_c;

  assign baud_last_c = (baud_q == BAUD_LAST);
  assign baud_pen_c  = (baud_q == BAUD_PEN);
  assign rd_last_c   = (rd_q == RD_LAST);
  assign bit_last_c  = (bit_q == BIT_LAST);

  // Two-flop synchroniser for the Fifo empty flag; resets to "empty" so
  // nothing is popped before the flag has been sampled.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      empty_meta_q <= 1'b1;
      empty_s_q    <= 1'b1;
    end else begin
      empty_meta_q <= iEmpty;
      empty_s_q    <= empty_meta_q;
    end
  end

  // Frame sequencer: pop strobe, baud timing, shifting and registered outputs.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q    <= ST_IDLE;
      oRdClkN    <= 1'b1;
      oTx        <= 1'b1;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
      baud_q     <= '0;
      rd_q       <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      oFrameDone <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iEnable && !empty_s_q) begin
            state_q <= ST_POP;
            oRdClkN <= 1'b0;
            oBusy   <= 1'b1;
            rd_q    <= '0;
          end
        end

        ST_POP: begin
          if (rd_last_c) begin
            shift_q <= iData;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^iData;
`endif
            state_q <= ST_START;
            oRdClkN <= 1'b1;
            oTx     <= 1'b0;
            baud_q  <= '0;
            rd_q    <= '0;
          end else begin
            rd_q <= rd_q + RD_W'(1);
          end
        end

        ST_START: begin
          if (baud_last_c) begin
            state_q <= ST_DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            oTx     <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        // shift_q always holds the bits not yet placed on the line
        ST_DATA: begin
          if (baud_last_c) begin
            baud_q <= '0;
            if (bit_last_c) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              oTx     <= parity_q;
`else
              state_q <= ST_STOP;
              oTx     <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              oTx     <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_last_c) begin
            state_q <= ST_STOP;
            baud_q  <= '0;
            oTx     <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`endif

        // Done pulse is registered one cycle early so it lands on the last stop cycle
        ST_STOP: begin
          if (baud_last_c) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            oBusy   <= 1'b0;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
            if (baud_pen_c) begin
              oFrameDone <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
